// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_pkg                                                      |
// | Brief   : Shared types and constants for the loopyV integer register file. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_I  = 32;
  localparam int NREGS_E  = 16;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  // True when the address names a register that exists in this configuration.
  function automatic logic inRange(input regaddr_t a, input int nregs);
    return int'({27'd0, a}) < nregs;
  endfunction
endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_sb_if                                                    |
// | Brief   : Read, write-back and issue signals between pipeline and regfile. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  regaddr_t [NRD-1:0]            rd_addr;
  logic     [NRD-1:0][XLEN-1:0]  rd_data;
  logic     [NRD-1:0]            rd_busy;
  logic     [NWR-1:0]            wr_en;
  regaddr_t [NWR-1:0]            wr_addr;
  logic     [NWR-1:0][XLEN-1:0]  wr_data;
  logic                          iss_en;
  regaddr_t                      iss_addr;
  logic                          illegal;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, illegal
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, illegal
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_scoreboard                                               |
// | Brief   : Per-register busy bits with set-over-clear and read-side mask.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_I,
  parameter int NRD   = 2
) (
  input  wire logic               clk,
  input  wire logic               arstn,
  input  wire logic               i_setEn,
  input  wire regaddr_t           i_setAddr,
  input  wire logic               i_clrEn,
  input  wire regaddr_t           i_clrAddr,
  input  wire regaddr_t [NRD-1:0] i_rdAddr,
  output logic          [NRD-1:0] o_rdBusy
);

  // Full 32-entry view: x0 and non-existent registers read as never busy.
  logic [31:0] w_busyView;

  for (genvar g = 0; g < 32; g++) begin : g_bit
    if (g == 0 || g >= NREGS) begin : g_none
      assign w_busyView[g] = 1'b0;
    end else begin : g_flop
      logic r_busy;
      // Set has priority: a new in-flight producer outlives the retiring one.
      always_ff @(posedge clk) begin
        if (!arstn) begin
          r_busy <= 1'b0;
        end else if (i_setEn && i_setAddr == 5'(g)) begin
          r_busy <= 1'b1;
        end else if (i_clrEn && i_clrAddr == 5'(g)) begin
          r_busy <= 1'b0;
        end
      end
      assign w_busyView[g] = r_busy;
    end
  end

  // A late write arriving now is bypassed to the reader, so it must not stall.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign o_rdBusy[p] = w_busyView[i_rdAddr[p]] & ~(i_clrEn && i_clrAddr == i_rdAddr[p]);
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_sb                                                       |
// | Brief   : N-read/M-write integer regfile with x0, bypass and scoreboard.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_I,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  wire logic    clk,
  input  wire logic    arstn,
  regfile_sb_if.slave  bus
);

  logic            w_wrEn0;
  logic            w_wrEn1;
  regaddr_t        w_wrAddr0;
  regaddr_t        w_wrAddr1;
  logic [XLEN-1:0] w_wrData0;
  logic [XLEN-1:0] w_wrData1;

  assign w_wrEn0   = bus.wr_en[0];
  assign w_wrAddr0 = bus.wr_addr[0];
  assign w_wrData0 = bus.wr_data[0];

  if (NWR > 1) begin : g_late
    assign w_wrEn1   = bus.wr_en[1];
    assign w_wrAddr1 = bus.wr_addr[1];
    assign w_wrData1 = bus.wr_data[1];
  end else begin : g_noLate
    assign w_wrEn1   = 1'b0;
    assign w_wrAddr1 = REG_ZERO;
    assign w_wrData1 = '0;
  end

  // Full 32-entry view; x0 and registers beyond NREGS have no flops.
  logic [XLEN-1:0] w_regView [32];

  for (genvar g = 0; g < 32; g++) begin : g_reg
    if (g == 0 || g >= NREGS) begin : g_none
      assign w_regView[g] = '0;
    end else begin : g_flop
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk) begin
        if (!arstn) begin
          r_q <= '0;
        end else if (w_wrEn1 && w_wrAddr1 == 5'(g)) begin
          r_q <= w_wrData1;
        end else if (w_wrEn0 && w_wrAddr0 == 5'(g)) begin
          r_q <= w_wrData0;
        end
      end
      assign w_regView[g] = r_q;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [XLEN-1:0] w_data;
    always_comb begin
      w_data = w_regView[bus.rd_addr[p]];
      if (w_wrEn0 && w_wrAddr0 == bus.rd_addr[p]) w_data = w_wrData0;
      if (w_wrEn1 && w_wrAddr1 == bus.rd_addr[p]) w_data = w_wrData1;
      if (bus.rd_addr[p] == REG_ZERO || !inRange(bus.rd_addr[p], NREGS)) w_data = '0;
    end
    assign bus.rd_data[p] = w_data;
  end

  if (NREGS < NREGS_I) begin : g_ill
    logic w_illegal;
    // Read ports have no enable, so any out-of-range read address counts.
    always_comb begin
      w_illegal = 1'b0;
      for (int p = 0; p < NRD; p++) begin
        if (!inRange(bus.rd_addr[p], NREGS)) w_illegal = 1'b1;
      end
      for (int k = 0; k < NWR; k++) begin
        if (bus.wr_en[k] && !inRange(bus.wr_addr[k], NREGS)) w_illegal = 1'b1;
      end
      if (bus.iss_en && !inRange(bus.iss_addr, NREGS)) w_illegal = 1'b1;
    end
    assign bus.illegal = w_illegal;
  end else begin : g_noIll
    assign bus.illegal = 1'b0;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk       (clk),
    .arstn     (arstn),
    .i_setEn   (bus.iss_en),
    .i_setAddr (bus.iss_addr),
    .i_clrEn   (w_wrEn1),
    .i_clrAddr (w_wrAddr1),
    .i_rdAddr  (bus.rd_addr),
    .o_rdBusy  (bus.rd_busy)
  );

endmodule
`default_nettype wire
